// File: rtl/magic_nor_pkg.sv
// Shared types and widths for the MAGIC NOR in-memory logic sequencer:
// opcodes, instruction layout, FSM states and a saturating counter helper.
package magic_nor_pkg;

  localparam int N_CELLS_DEF    = 64;
  localparam int PROG_DEPTH_DEF = 64;
  localparam int CELL_W         = $clog2(N_CELLS_DEF);
  localparam int PC_W           = $clog2(PROG_DEPTH_DEF);

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_NOR2 = 2'd1,
    OP_INV  = 2'd2,
    OP_END  = 2'd3
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [CELL_W-1:0] a;
    logic [CELL_W-1:0] b;
    logic [CELL_W-1:0] y;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/magic_prog_mem.sv
// Instruction store: one synchronous write port, asynchronous read by pc.
// Contents survive reset so a program can be rerun after an abort.
module magic_prog_mem
  import magic_nor_pkg::*;
#(
  parameter int DEPTH = PROG_DEPTH_DEF,
  parameter int AW    = PC_W,
  parameter int DW    = INSTR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/magic_nor_sequencer.sv
// Emulates one memristor crossbar row executing a stored MAGIC NOR/INV program:
// each gate is an INIT cycle (output cell set to 1) followed by an EVAL cycle (conditional reset to 0).
module magic_nor_sequencer
  import magic_nor_pkg::*;
#(
  parameter int N_CELLS    = N_CELLS_DEF,
  parameter int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter int N_IN       = 8,
  parameter int N_OUT      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [INSTR_W-1:0]            prog_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT-1:0]              out_data,
  output logic                          err,
  output logic [15:0]                   cycle_count
);

  localparam int AW = $clog2(PROG_DEPTH);

  state_e              state_reg;
  logic [AW-1:0]       pc_reg;
  logic [N_CELLS-1:0]  cells_reg;
  logic                err_reg;
  logic [15:0]         cycle_count_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;

  logic [INSTR_W-1:0]  rd_data;
  instr_t              instr;
  logic                idx_fault;
  logic                hazard;
  logic                last_slot;
  logic                eval_bit;

  // Writes land before the first INIT read, so a same-cycle write and start sees new contents.
  magic_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW),
    .DW    (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state_reg == ST_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_reg),
    .rdata (rd_data)
  );

  assign instr = instr_t'(rd_data);

  always_comb begin
    idx_fault = (int'(instr.a) >= N_CELLS) || (int'(instr.y) >= N_CELLS) ||
                ((instr.op == OP_NOR2) && (int'(instr.b) >= N_CELLS));
    hazard    = (instr.a == instr.y) || ((instr.op == OP_NOR2) && (instr.b == instr.y));
    last_slot = (pc_reg == AW'(PROG_DEPTH - 1));
    // INV ignores b; the output cell can only fall, never rise, during EVAL.
    eval_bit  = cells_reg[instr.y] &
                ~(cells_reg[instr.a] | ((instr.op == OP_NOR2) ? cells_reg[instr.b] : 1'b0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= '0;
      cells_reg       <= '0;
      err_reg         <= 1'b0;
      cycle_count_reg <= '0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            cells_reg       <= N_CELLS'(in_data);
            pc_reg          <= '0;
            cycle_count_reg <= '0;
            err_reg         <= 1'b0;
            in_ready_reg    <= 1'b0;
            state_reg       <= ST_INIT;
          end
        end
        ST_INIT: begin
          cycle_count_reg <= sat_inc16(cycle_count_reg);
          case (instr.op)
            OP_END: begin
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end
            OP_NOP: begin
              if (last_slot) begin
                err_reg       <= 1'b1;
                out_valid_reg <= 1'b1;
                state_reg     <= ST_DONE;
              end else begin
                pc_reg <= pc_reg + AW'(1);
              end
            end
            default: begin
              if (idx_fault || hazard) begin
                err_reg       <= 1'b1;
                out_valid_reg <= 1'b1;
                state_reg     <= ST_DONE;
              end else begin
                cells_reg[instr.y] <= 1'b1;
                state_reg          <= ST_EVAL;
              end
            end
          endcase
        end
        ST_EVAL: begin
          cycle_count_reg    <= sat_inc16(cycle_count_reg);
          cells_reg[instr.y] <= eval_bit;
          if (last_slot) begin
            err_reg       <= 1'b1;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            pc_reg    <= pc_reg + AW'(1);
            state_reg <= ST_INIT;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out_data[gi] = cells_reg[N_CELLS - N_OUT + gi];
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign err         = err_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Directed bench for magic_nor_sequencer: small gate programs, a 5-input
// parity/zero netlist over all 32 vectors, hazards, overflow and mid-run reset.
module tb_magic_nor_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        err;
  logic [15:0] cycle_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic        pend_we = 1'b0;
  logic [5:0]  pend_addr = '0;
  logic [19:0] pend_data = '0;
  int          pa;
  int          nc;

  localparam logic [1:0] NOP = 2'd0, NOR2 = 2'd1, INV = 2'd2, ENDI = 2'd3;

  magic_nor_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .err         (err),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ins(input logic [1:0] op, input int a, input int b, input int y);
    logic [5:0] fa, fb, fy;
    fa = a[5:0];
    fb = b[5:0];
    fy = y[5:0];
    return {op, fa, fb, fy};
  endfunction

  task automatic prog_write(input int addr, input logic [19:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[5:0];
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic emit(input logic [1:0] op, input int a, input int b, input int y);
    prog_write(pa, ins(op, a, b, y));
    pa++;
  endtask

  // XOR from four NOR2 (yields XNOR) plus one INV.
  task automatic emit_xor(input int a, input int b, input int dst);
    int t;
    t = nc;
    nc += 4;
    emit(NOR2, a, b, t);
    emit(NOR2, a, t, t + 1);
    emit(NOR2, b, t, t + 2);
    emit(NOR2, t + 1, t + 2, t + 3);
    emit(INV, t + 3, 0, dst);
  endtask

  task automatic run(input logic [7:0] din, output logic [3:0] dout,
                     output logic e, output logic [15:0] cc);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = din;
    if (pend_we) begin
      prog_we   = 1'b1;
      prog_addr = pend_addr;
      prog_data = pend_data;
    end
    @(negedge clk);
    in_valid = 1'b0;
    prog_we  = 1'b0;
    pend_we  = 1'b0;
    waited   = 0;
    while (!out_valid && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("out_valid_reached", 32'(out_valid), 32'd1);
    dout = out_data;
    e    = err;
    cc   = cycle_count;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_done", 32'(in_ready), 32'd1);
    $display("run in=0x%02h out=0x%0h err=%0d cycles=%0d", din, dout, e, cc);
  endtask

  task automatic run_check(input string tag, input logic [7:0] din, input logic [3:0] exp_out,
                           input logic exp_err, input int exp_cc);
    logic [3:0]  d;
    logic        e;
    logic [15:0] cc;
    run(din, d, e, cc);
    chk({tag, "_out"}, 32'(d), 32'(exp_out));
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_cycles"}, 32'(cc), exp_cc[31:0]);
  endtask

  initial begin
    logic [3:0]  d;
    logic        e;
    logic [15:0] cc;
    logic [4:0]  v;
    int          pop;
    int          x01, x012, x0123;
    int          g, o, o2, o3, o4, o5;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Single NOR2 of cells 0,1 into cell 63.
    prog_write(0, ins(NOR2, 0, 1, 63));
    prog_write(1, ins(ENDI, 0, 0, 0));
    run_check("nor_00", 8'h00, 4'h8, 1'b0, 3);
    run_check("nor_01", 8'h01, 4'h0, 1'b0, 3);
    run_check("nor_02", 8'h02, 4'h0, 1'b0, 3);
    run_check("nor_04", 8'h04, 4'h8, 1'b0, 3);

    // NOP inserted; slot 1 rewritten in the same cycle as the start handshake.
    prog_write(2, ins(ENDI, 0, 0, 0));
    pend_we = 1'b1; pend_addr = 6'd1; pend_data = ins(NOP, 0, 0, 0);
    run_check("nop_end", 8'h00, 4'h8, 1'b0, 4);

    // INV of cell 2 into cell 62.
    prog_write(0, ins(INV, 2, 0, 62));
    prog_write(1, ins(ENDI, 0, 0, 0));
    run_check("inv_0", 8'h00, 4'h4, 1'b0, 3);
    run_check("inv_1", 8'h04, 4'h0, 1'b0, 3);

    // Operand hazards abort before the output cell is initialised.
    prog_write(0, ins(NOR2, 63, 0, 63));
    run_check("hazard_ay", 8'h00, 4'h0, 1'b1, 1);
    prog_write(0, ins(NOR2, 0, 62, 62));
    run_check("hazard_by", 8'h00, 4'h0, 1'b1, 1);
    prog_write(0, ins(NOR2, 5, 7, 5));
    run_check("hazard_575", 8'h20, 4'h0, 1'b1, 1);

    // Symmetric 5-input netlist: cell 60 = parity, cell 61 = all-zero.
    pa = 0;
    nc = 8;
    x01 = nc; nc++;
    emit_xor(0, 1, x01);
    x012 = nc; nc++;
    emit_xor(x01, 2, x012);
    x0123 = nc; nc++;
    emit_xor(x012, 3, x0123);
    emit_xor(x0123, 4, 60);
    g = nc; o = nc + 1; o2 = nc + 2; o3 = nc + 3; o4 = nc + 4; o5 = nc + 5;
    emit(NOR2, 0, 1, g);
    emit(INV, g, 0, o);
    emit(NOR2, o, 2, o2);
    emit(INV, o2, 0, o3);
    emit(NOR2, o3, 3, o4);
    emit(INV, o4, 0, o5);
    emit(NOR2, o5, 4, 61);
    emit(ENDI, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      v   = i[4:0];
      pop = 0;
      for (int k = 0; k < 5; k++) pop += int'(v[k]);
      run_check($sformatf("sym_%0d", i), {3'b000, v},
                {2'b00, (pop == 0), (pop % 2 == 1)}, 1'b0, 55);
    end

    // No END anywhere: 64 gates then overflow error.
    for (int s = 0; s < 64; s++) prog_write(s, ins(NOR2, 0, 1, 63));
    run_check("overflow", 8'h00, 4'h8, 1'b1, 128);

    // Reset during EVAL; a write attempted mid-run must be ignored.
    prog_write(1, ins(ENDI, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    in_valid  = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 6'd1;
    prog_data = ins(NOP, 0, 0, 0);
    @(negedge clk);
    prog_we = 1'b0;
    chk("eval_out_valid", 32'(out_valid), 32'd0);
    chk("eval_cell63_set", 32'(out_data), 32'h8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_cycle_count", 32'(cycle_count), 32'd0);
    run_check("rerun", 8'h00, 4'h8, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/magic_nor_sequencer.md
MAGIC_NOR_SEQUENCER -- requirements
Module: magic_nor_sequencer

Interface
REQ-001 Parameter N_CELLS, default 64: number of single-bit memristor cells in the emulated crossbar row.
REQ-002 Parameter PROG_DEPTH, default 64: number of instruction slots.
REQ-003 Parameter N_IN, default 8: input bits, loaded into cells 0..N_IN-1.
REQ-004 Parameter N_OUT, default 4: output bits, read from cells N_CELLS-N_OUT..N_CELLS-1.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 prog_we  in  1  program write strobe.
REQ-009 prog_addr  in  log2(PROG_DEPTH)  program slot address.
REQ-010 prog_data  in  2+3*log2(N_CELLS)  instruction {op, a, b, y}; op: 0 NOP, 1 NOR2, 2 INV (uses a only), 3 END.
REQ-011 in_valid  in  1  input vector valid; handshake starts a run.
REQ-012 in_ready  out  1  high only in IDLE.
REQ-013 in_data  in  N_IN  primary inputs.
REQ-014 out_valid  out  1  result available (DONE state).
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_data  out  N_OUT  result cells, bit i = cell[N_CELLS-N_OUT+i].
REQ-017 err  out  1  run aborted by a fault; valid with out_valid.
REQ-018 cycle_count  out  16  INIT+EVAL cycles used by the last run; saturates at 0xFFFF.

Function
REQ-019 FSM states SHALL be IDLE, INIT, EVAL, DONE.
REQ-020 IDLE: on in_valid&in_ready, the block SHALL write in_data into cells 0..N_IN-1, clear all other cells, set pc=0, cycle_count=0, err=0, and go to INIT.
REQ-021 INIT decodes instr[pc]: END -> DONE; NOP -> pc+1, stay INIT; NOR2/INV -> cell[y]=1, go EVAL.
REQ-022 EVAL: NOR2 SHALL write cell[y] = cell[y] & ~(cell[a]|cell[b]); INV SHALL write cell[y] = cell[y] & ~cell[a]; then pc+1 and return to INIT (MAGIC semantics: a cell only switches 1->0 in EVAL).
REQ-023 cycle_count SHALL increment once per cycle spent in INIT or EVAL, saturating.
REQ-024 Operand hazard: if a==y (or b==y for NOR2) the block SHALL skip the write, set err=1, and go to DONE.
REQ-025 Index fault: any a, b, or y >= N_CELLS SHALL set err=1 and go to DONE.
REQ-026 Program overflow: reaching pc==PROG_DEPTH-1 with op != END SHALL execute that slot, then set err=1 and go to DONE.
REQ-027 DONE: out_valid=1 and out_data, err, and cycle_count stable; on out_ready, go to IDLE in the next cycle.
REQ-028 prog_we SHALL be honoured only in IDLE; writes in any other state are ignored.
REQ-029 A prog_we and an in_valid handshake in the same IDLE cycle: the write completes first, and the run uses the new contents.

Reset
REQ-030 rst SHALL force IDLE, pc=0, all cells=0, out_valid=0, err=0, cycle_count=0, in_ready=1 from the next cycle, including mid-run.
REQ-031 Program memory SHALL NOT be cleared by rst.

Structure
REQ-032 Package magic_nor_pkg SHALL hold the opcode enum, the instruction struct, and the field-width constants derived from N_CELLS and PROG_DEPTH.
REQ-033 Program storage SHALL be the sub-module magic_prog_mem (write port, combinational read by pc).

Verification
REQ-034 Prog {NOR2 a=0 b=1 y=63; END}, in_data=0x00 -> out_data[3]=1, err=0, cycle_count=3.
REQ-035 Same program, in_data=0x01 -> out_data[3]=0; NOP inserted before END -> cycle_count=4.
REQ-036 Load a NOR/INV netlist of a 5-input symmetric function into cells 0..4 and run all 32 vectors -> out_data matches a popcount-based golden model, err=0.
REQ-037 Instruction NOR2 a=5 b=7 y=5 -> DONE with err=1 and cell 5 unchanged.
REQ-038 Program with no END -> err=1 after slot 63; cycle_count=128 for 64 gates.
REQ-039 rst asserted during EVAL -> next cycle IDLE, out_valid=0, cells=0, and program memory intact on the rerun.
